// File: rtl/wm8978_i2c_slave_if.sv
// Register-side interface of the WM8978 control-port responder.
// Carries the user readback port and the commit/status outputs.
//   rd_addr  user readback address (driven by the user side)
//   rd_data  register value at rd_addr, 0 outside the implemented range
//   wr_en    one-clock pulse per committed register write
//   wr_addr  address of the last committed write
//   wr_data  data of the last committed write
//   busy     high while a transaction is open (START seen, no STOP yet)
//   wr_cnt   committed writes since reset, wraps 255 -> 0
`timescale 1ns/1ps
interface wm8978_i2c_slave_if;
  logic [6:0] rd_addr;
  logic [8:0] rd_data;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic [7:0] wr_cnt;

  modport slave  (input  rd_addr,
                  output rd_data, wr_en, wr_addr, wr_data, busy, wr_cnt);
  modport master (output rd_addr,
                  input  rd_data, wr_en, wr_addr, wr_data, busy, wr_cnt);
endinterface

// File: rtl/wm8978_i2c_slave.sv
// Write-only I2C responder emulating the WM8978 control port.
// Accepts 3-byte frames (device address, {reg[6:0], data[8]}, data[7:0]),
// ACKs them and stores the 9-bit value in an internal register file.
// SCL/SDA are oversampled on clk; nothing is clocked by SCL.
// Ports:
//   clk      system clock, at least 16x the SCL frequency
//   rst_n    asynchronous active-low reset
//   scl      I2C clock input (never stretched)
//   sda      I2C data, pulled low only for ACK, otherwise released
//   regs_if  register-side port (readback, commit strobe, status)
`timescale 1ns/1ps
module wm8978_i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1a,
  parameter int         NUM_REGS   = 58
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  inout  wire  sda,
  wm8978_i2c_slave_if.slave regs_if
);

  localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);
  localparam logic [7:0] DEV_WRITE  = {SLAVE_ADDR, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2, S_IGNORE
  } state_t;

  state_t state, state_n;

  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       byte_full;
  logic [6:0] reg_addr;
  logic       d8;

  logic shift_en, restart, byte_take, latch_b1, commit, sda_drive;
  logic reg_in_range;

  logic [8:0] regs [NUM_REGS];
  logic       wr_en_r;
  logic [6:0] wr_addr_r;
  logic [8:0] wr_data_r;
  logic [7:0] wr_cnt_r;

  // Open-drain output: the only value ever driven is 0 during an ACK bit.
  // It is decoded straight from the state so reset releases the line at once.
  assign sda = sda_drive ? 1'b0 : 1'bz;

  // Two-stage synchronisers plus a delayed copy for edge detection.
  // Idle-high reset values keep the first samples from looking like edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_prev <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_meta <= scl;
      scl_sync <= scl_meta;
      scl_prev <= scl_sync;
      sda_meta <= sda;
      sda_sync <= sda_meta;
      sda_prev <= sda_sync;
    end
  end

  // START/STOP require scl to have been high on both samples so a data
  // change racing an scl edge is never mistaken for a bus condition.
  assign scl_rise  =  scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync &  scl_prev;
  assign start_det =  scl_sync &  scl_prev & ~sda_sync &  sda_prev;
  assign stop_det  =  scl_sync &  scl_prev &  sda_sync & ~sda_prev;

  assign reg_in_range = ({1'b0, reg_addr} < NUM_REGS_B);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state and control decode. Bus conditions win over bit events in
  // every state. Byte states move to their ACK state on the scl fall that
  // ends bit 8; ACK states hand over on the fall that ends the ACK bit.
  always_comb begin
    state_n   = state;
    shift_en  = 1'b0;
    restart   = 1'b0;
    byte_take = 1'b0;
    latch_b1  = 1'b0;
    commit    = 1'b0;
    sda_drive = (state == S_DEV_ACK) || (state == S_ACK1) || (state == S_ACK2);
    regs_if.busy = (state != S_IDLE);

    if (start_det) begin
      state_n = S_DEV_ADDR;
      restart = 1'b1;
    end else if (stop_det) begin
      state_n = S_IDLE;
      restart = 1'b1;
    end else begin
      unique case (state)
        S_DEV_ADDR: begin
          if (scl_rise) shift_en = 1'b1;
          else if (scl_fall && byte_full) begin
            byte_take = 1'b1;
            state_n   = (shreg == DEV_WRITE) ? S_DEV_ACK : S_IGNORE;
          end
        end
        S_DEV_ACK: if (scl_fall) state_n = S_BYTE1;
        S_BYTE1: begin
          if (scl_rise) shift_en = 1'b1;
          else if (scl_fall && byte_full) begin
            byte_take = 1'b1;
            latch_b1  = 1'b1;
            state_n   = S_ACK1;
          end
        end
        S_ACK1: if (scl_fall) state_n = S_BYTE2;
        S_BYTE2: begin
          if (scl_rise) shift_en = 1'b1;
          else if (scl_fall && byte_full) begin
            byte_take = 1'b1;
            commit    = 1'b1;
            state_n   = S_ACK2;
          end
        end
        S_ACK2: if (scl_fall) state_n = S_IGNORE;
        S_IDLE, S_IGNORE: state_n = state;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Byte assembly: MSB first, byte_full marks that eight bits are waiting
  // for the closing scl fall. A bus condition throws away a partial byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= 8'h00;
      bit_cnt   <= 3'd0;
      byte_full <= 1'b0;
      reg_addr  <= 7'h00;
      d8        <= 1'b0;
    end else begin
      if (restart) begin
        bit_cnt   <= 3'd0;
        byte_full <= 1'b0;
      end else begin
        if (shift_en) begin
          shreg   <= {shreg[6:0], sda_sync};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_full <= 1'b1;
        end
        if (byte_take) byte_full <= 1'b0;
      end
      if (latch_b1) begin
        reg_addr <= shreg[7:1];
        d8       <= shreg[0];
      end
    end
  end

  // Register file and commit outputs. An out-of-range address is still
  // ACKed on the bus but leaves every register and output untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'h000;
      wr_en_r   <= 1'b0;
      wr_addr_r <= 7'h00;
      wr_data_r <= 9'h000;
      wr_cnt_r  <= 8'h00;
    end else begin
      wr_en_r <= 1'b0;
      if (commit && reg_in_range) begin
        regs[reg_addr[AW-1:0]] <= {d8, shreg};
        wr_en_r   <= 1'b1;
        wr_addr_r <= reg_addr;
        wr_data_r <= {d8, shreg};
        wr_cnt_r  <= wr_cnt_r + 8'd1;
      end
    end
  end

  // Combinational readback, zero outside the implemented range.
  always_comb begin
    regs_if.rd_data = 9'h000;
    if ({1'b0, regs_if.rd_addr} < NUM_REGS_B)
      regs_if.rd_data = regs[regs_if.rd_addr[AW-1:0]];
  end

  assign regs_if.wr_en   = wr_en_r;
  assign regs_if.wr_addr = wr_addr_r;
  assign regs_if.wr_data = wr_data_r;
  assign regs_if.wr_cnt  = wr_cnt_r;

endmodule

// File: tb/tb_wm8978_i2c_slave.sv
// Self-checking bench for wm8978_i2c_slave.
// A bus-master model drives I2C frames; expected commits go into a
// scoreboard queue that a monitor drains on every wr_en pulse. ACK bits,
// busy and readback are compared against a behavioural register model.
`timescale 1ns/1ps
module tb_wm8978_i2c_slave;

  localparam logic [7:0] DEV_W = 8'h34;
  localparam int         NREGS = 58;

  typedef struct {
    int addr;
    int data;
    int cnt;
  } exp_t;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic scl       = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  wm8978_i2c_slave_if rif ();

  wm8978_i2c_slave #(.SLAVE_ADDR(7'h1a), .NUM_REGS(NREGS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl     (scl),
    .sda     (sda),
    .regs_if (rif)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_regs [128];
  int   model_cnt = 0;
  exp_t sb [$];
  exp_t mon_e;
  bit   drive_seen = 1'b0;

  // Bit timing in clk cycles: low phase before/after the data change, high phase.
  int lo_pre  = 6;
  int lo_post = 2;
  int hi      = 8;

  task automatic check_output(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every commit strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rif.wr_en) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_commit: got wr_addr 0x%0h wr_data 0x%0h, expected no commit",
                 rif.wr_addr, rif.wr_data);
      end else begin
        mon_e = sb.pop_front();
        check_output("wr_addr", int'(rif.wr_addr), mon_e.addr);
        check_output("wr_data", int'(rif.wr_data), mon_e.data);
        check_output("wr_cnt",  int'(rif.wr_cnt),  mon_e.cnt);
      end
    end
  end

  // Flags any low level on sda that the master is not responsible for.
  always @(negedge clk) begin
    #2;
    if (!m_sda_low && sda === 1'b0) drive_seen = 1'b1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      wait_clk(lo_pre);
      m_sda_low = 1'b0;
      wait_clk(lo_post);
      scl = 1'b1;
    end
    wait_clk(hi);
    m_sda_low = 1'b1;
    wait_clk(hi);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(lo_pre);
    m_sda_low = 1'b1;
    wait_clk(lo_post);
    scl = 1'b1;
    wait_clk(hi);
    m_sda_low = 1'b0;
    wait_clk(hi);
  endtask

  task automatic send_bit(input bit b);
    wait_clk(lo_pre);
    m_sda_low = !b;
    wait_clk(lo_post);
    scl = 1'b1;
    wait_clk(hi);
    scl = 1'b0;
  endtask

  task automatic send_byte_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic read_ack(output bit ack);
    wait_clk(lo_pre);
    m_sda_low = 1'b0;
    wait_clk(lo_post);
    scl = 1'b1;
    wait_clk(hi / 2);
    ack = (sda === 1'b0);
    wait_clk(hi - hi / 2);
    scl = 1'b0;
  endtask

  // One frame of up to four bytes. The reference model decides the ACK of
  // every byte and whether the frame commits, before the bus is touched.
  task automatic apply_stimulus(input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input int nbytes, input bit do_stop);
    logic [7:0] bytes [4];
    bit dev_ok;
    bit ack;
    int ra;
    int rd;
    bytes  = '{b0, b1, b2, b3};
    dev_ok = (b0 == DEV_W);
    ra     = int'(b1[7:1]);
    rd     = int'({b1[0], b2});
    if (dev_ok && nbytes >= 3 && ra < NREGS) begin
      model_regs[ra] = rd;
      model_cnt      = (model_cnt + 1) % 256;
      sb.push_back('{ra, rd, model_cnt});
    end
    i2c_start();
    for (int k = 0; k < nbytes; k++) begin
      send_byte_bits(bytes[k]);
      read_ack(ack);
      check_output($sformatf("ack_byte%0d", k), int'(ack), int'(dev_ok && k < 3));
      if (k == 0) check_output("busy_in_frame", int'(rif.busy), 1);
    end
    if (do_stop) begin
      i2c_stop();
      wait_clk(2);
      check_output("busy_after_stop", int'(rif.busy), 0);
    end
  endtask

  task automatic check_reg(input int a);
    rif.rd_addr = 7'(a);
    #1;
    check_output($sformatf("rd_data[%0d]", a), int'(rif.rd_data),
                 (a < NREGS) ? model_regs[a] : 0);
  endtask

  initial begin
    #950_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion before time limit");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    bit ack;
    rif.rd_addr = 7'h00;
    for (int i = 0; i < 128; i++) model_regs[i] = 0;

    // Reset values
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(2);
    check_output("rst_busy",    int'(rif.busy),    0);
    check_output("rst_wr_en",   int'(rif.wr_en),   0);
    check_output("rst_wr_cnt",  int'(rif.wr_cnt),  0);
    check_output("rst_wr_addr", int'(rif.wr_addr), 0);
    check_output("rst_wr_data", int'(rif.wr_data), 0);
    check_output("rst_sda",     int'(sda === 1'b1), 1);
    check_reg(3);

    // Basic write: reg 3 <= 0x16F
    apply_stimulus(8'h34, 8'h07, 8'h6F, 8'h00, 3, 1'b1);
    check_reg(3);
    check_output("wr_cnt_after_first", int'(rif.wr_cnt), model_cnt);

    // Wrong device address: never driven
    drive_seen = 1'b0;
    apply_stimulus(8'h36, 8'h07, 8'h00, 8'h00, 3, 1'b1);
    check_output("no_drive_wrong_addr", int'(drive_seen), 0);
    check_reg(3);

    // Read request NACKed, then a clean frame
    drive_seen = 1'b0;
    apply_stimulus(8'h35, 8'h00, 8'h00, 8'h00, 1, 1'b1);
    check_output("no_drive_read", int'(drive_seen), 0);
    apply_stimulus(8'h34, 8'h0C, 8'h55, 8'h00, 3, 1'b1);
    check_reg(6);

    // Out-of-range register, then an over-long frame
    apply_stimulus(8'h34, 8'h7E, 8'h01, 8'h00, 3, 1'b1);
    check_output("wr_cnt_oor", int'(rif.wr_cnt), model_cnt);
    apply_stimulus(8'h34, 8'h02, 8'hFF, 8'hAA, 4, 1'b1);
    check_reg(1);
    check_reg(57);
    check_reg(58);

    // STOP after two bytes, repeated START mid-frame, then a full frame
    apply_stimulus(8'h34, 8'h07, 8'h00, 8'h00, 2, 1'b1);
    apply_stimulus(8'h34, 8'h09, 8'h00, 8'h00, 2, 1'b0);
    apply_stimulus(8'h34, 8'h09, 8'h12, 8'h00, 3, 1'b1);
    check_reg(3);
    check_reg(4);

    // Randomised frames, mixed endings
    for (int n = 0; n < 12; n++) begin
      logic [7:0] dv;
      dv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : DEV_W;
      apply_stimulus(dv, {6'($urandom_range(0, 63)), 2'($urandom)}, 8'($urandom),
                     8'($urandom), int'($urandom_range(1, 4)),
                     (n == 11) ? 1'b1 : 1'($urandom));
    end
    for (int a = 0; a < 64; a += 7) check_reg(a);

    // Reset during ACK1 releases sda at once and clears everything
    i2c_start();
    send_byte_bits(8'h34);
    read_ack(ack);
    check_output("ack_before_reset", int'(ack), 1);
    send_byte_bits(8'h07);
    wait_clk(lo_pre);
    m_sda_low = 1'b0;
    wait_clk(1);
    check_output("ack1_driving", int'(sda === 1'b0), 1);
    rst_n = 1'b0;
    #1;
    check_output("rst_sda_release", int'(sda === 1'b1), 1);
    for (int i = 0; i < 128; i++) model_regs[i] = 0;
    model_cnt = 0;
    check_output("rst_busy2",    int'(rif.busy),    0);
    check_output("rst_wr_cnt2",  int'(rif.wr_cnt),  0);
    check_output("rst_wr_addr2", int'(rif.wr_addr), 0);
    check_output("rst_wr_data2", int'(rif.wr_data), 0);
    check_output("sb_empty_at_reset", sb.size(), 0);
    check_reg(3);
    check_reg(6);
    scl = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);

    // 256 commits wrap wr_cnt; a shorter bit period keeps this stretch brief
    // while still leaving several clocks past the synchroniser lag.
    lo_pre  = 3;
    lo_post = 1;
    hi      = 3;
    for (int n = 0; n < 256; n++)
      apply_stimulus(DEV_W, {7'($urandom_range(0, NREGS - 1)), 1'($urandom)},
                     8'($urandom), 8'h00, 3, 1'b1);
    wait_clk(4);
    check_output("wr_cnt_wrap", int'(rif.wr_cnt), model_cnt);

    for (int a = 0; a < 128; a++) check_reg(a);
    wait_clk(4);
    check_output("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
